// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes datapath memory accesses to block RAM or to the
// memory-mapped I/O registers: LEDs, switches, TX FIFO and cycle counter.
// Read data has a 1-cycle latency on both paths.
// Optional feature macro: MEMIO_TIMER_EN (cycle counter at IO_BASE+3).
module mem_io_bridge #(
  parameter int unsigned RAM_AW   = 10,
  parameter logic [15:0] IO_BASE  = 16'hFF00,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_addr,
  input  logic              mem_we,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

  logic          is_io;
  logic [15:0]   io_off;
  logic          io_wr;
  logic          wr_led, wr_tx, wr_ctl;
  logic [15:0]   io_rd_val;
  logic [15:0]   cnt_val;

  logic          sel_q;
  logic [15:0]   io_q;
  logic [15:0]   led_q;
  logic [15:0]   sw_s1_q, sw_s2_q;

  logic [15:0]   fifo_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          full, empty, push, pop;

  assign is_io     = (mem_addr >= IO_BASE);
  assign io_off    = mem_addr - IO_BASE;
  assign io_wr     = mem_we & is_io;
  assign wr_led    = io_wr & (io_off == 16'd0);
  assign wr_tx     = io_wr & (io_off == 16'd2);
  assign wr_ctl    = io_wr & (io_off == 16'd4);

  assign ram_addr  = mem_addr[RAM_AW-1:0];
  assign ram_wdata = mem_wdata;
  assign ram_we    = mem_we & ~is_io;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = wr_tx & ~full;
  assign pop       = ~empty & tx_ready;
  assign tx_valid  = ~empty;
  assign tx_data   = fifo_q[rd_ptr_q];
  assign led_out   = led_q;
  assign mem_rdata = sel_q ? io_q : ram_rdata;

`ifdef MEMIO_TIMER_EN
  logic        wr_cnt;
  logic [15:0] cnt_q;
  assign wr_cnt  = io_wr & (io_off == 16'd3);
  assign cnt_val = cnt_q;

  // Free-running cycle counter; a write zeroes it as of the write cycle,
  // so the register already holds 1 in the cycle after the write.
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (wr_cnt) cnt_q <= 16'd1;
    else             cnt_q <= cnt_q + 16'd1;
  end
`else
  assign cnt_val = '0;
`endif

  // I/O read mux for the address currently presented
  always_comb begin
    io_rd_val = '0;
    case (io_off)
      16'd0:   io_rd_val = led_q;
      16'd1:   io_rd_val = sw_s2_q;
      16'd2:   io_rd_val = {8'(count_q), 5'b0, ovf_q, empty, full};
      16'd3:   io_rd_val = cnt_val;
      default: io_rd_val = '0;
    endcase
  end

  // Read-path registers matching block RAM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
      io_q  <= '0;
    end else begin
      sel_q <= is_io;
      io_q  <= io_rd_val;
    end
  end

  // LED register and switch synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      if (wr_led) led_q <= mem_wdata;
      sw_s1_q <= sw_in;
      sw_s2_q <= sw_s1_q;
    end
  end

  // TX FIFO storage; contents need no reset since pointers/count gate them
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_wdata;
  end

  // TX FIFO pointers, count and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (wr_tx && full) ovf_q <= 1'b1;
      else if (wr_ctl)   ovf_q <= 1'b0;
    end
  end

endmodule
